// File: rtl/cim_cmd_seq.sv
// cim_cmd_seq: command sequencer in front of the CIM array controller.
// Buffers host burst commands (MAC / write / read / NOP) in a 2-entry FIFO
// and expands each one into per-cycle array operations on registered outputs.
// Optional feature macro: CIM_SEQ_MAC_GATE_EN -- when defined, data_in is only
// driven in the first cycle of each MAC beat and is zero in the others.
module cim_cmd_seq #(
  parameter int unsigned MAC_CYC = 2,  // cycles per MAC beat (1..15)
  parameter int unsigned GAP_CYC = 1   // NOP cycles after every command (0..3)
) (
  input  logic        clk_inv,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_bank,
  input  logic [2:0]  cmd_col,
  input  logic [3:0]  cmd_len,
  input  logic [15:0] cmd_data,
  output logic [1:0]  op_code,
  output logic [3:0]  addr_bank,
  output logic [2:0]  addr_col,
  output logic [15:0] data_bank,
  output logic [15:0] data_in,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] OP_MAC = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] MAC_LAST = 4'(MAC_CYC - 1);
  localparam logic [1:0] GAP_LAST = 2'(GAP_CYC - 1);
  localparam bit         GAP_EN   = (GAP_CYC != 0);

  typedef struct packed {
    logic [1:0]  op;
    logic [3:0]  bank;
    logic [2:0]  col;
    logic [3:0]  len;
    logic [15:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  // Command FIFO storage and pointers
  cmd_t       r_fifo [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  // Sequencer state and working copy of the command being issued
  state_t      r_state;
  logic [1:0]  r_op;
  logic [3:0]  r_beat_cnt;
  logic [3:0]  r_cyc_cnt;
  logic [1:0]  r_gap_cnt;
  logic [15:0] r_data;

  // Registered array-side outputs
  logic [1:0]  r_op_code;
  logic [3:0]  r_addr_bank;
  logic [2:0]  r_addr_col;
  logic [15:0] r_data_bank;
  logic [15:0] r_data_in;
  logic        r_done;

  cmd_t        w_cmd_in;
  cmd_t        w_head;
  logic        w_push;
  logic        w_pop;
  logic        w_fifo_ne;
  logic        w_beat_end;
  logic        w_cmd_end;
  logic        w_gap_end;
  logic [3:0]  w_next_bank;
  logic [2:0]  w_next_col;

  assign w_cmd_in  = '{op: cmd_op, bank: cmd_bank, col: cmd_col, len: cmd_len, data: cmd_data};
  assign w_head    = r_fifo[r_rd_ptr];
  assign w_fifo_ne = (r_count != 2'd0);
  // A full FIFO refuses the push even if a pop happens on the same edge.
  assign w_push    = cmd_valid && (r_count != 2'd2);

  assign cmd_ready = (r_count != 2'd2);
  assign busy      = (r_state != ST_IDLE) || w_fifo_ne;
  assign op_code   = r_op_code;
  assign addr_bank = r_addr_bank;
  assign addr_col  = r_addr_col;
  assign data_bank = r_data_bank;
  assign data_in   = r_data_in;
  assign done      = r_done;

  // Beat/command/gap boundary detection and the FIFO pop decision
  always_comb begin
    w_beat_end = 1'b0;
    w_cmd_end  = 1'b0;
    w_gap_end  = 1'b0;
    w_pop      = 1'b0;
    if (r_op == OP_MAC) begin
      w_beat_end = (r_cyc_cnt == 4'd0);
    end else begin
      w_beat_end = 1'b1;
    end
    if (r_state == ST_ISSUE) begin
      // A NOP occupies a single slot with no beats, then completes.
      w_cmd_end = (r_op == OP_NOP) || (w_beat_end && (r_beat_cnt == 4'd0));
    end else begin
      w_cmd_end = 1'b0;
    end
    if (r_state == ST_GAP) begin
      w_gap_end = (r_gap_cnt == 2'd0);
    end else begin
      w_gap_end = 1'b0;
    end
    if (w_fifo_ne) begin
      w_pop = (r_state == ST_IDLE) || (w_cmd_end && !GAP_EN) || w_gap_end;
    end else begin
      w_pop = 1'b0;
    end
  end

  // Address stepping for the next beat: write walks banks, read walks columns then banks
  always_comb begin
    w_next_bank = r_addr_bank;
    w_next_col  = r_addr_col;
    case (r_op)
      OP_WR: begin
        w_next_bank = r_addr_bank + 4'd1;
        w_next_col  = r_addr_col;
      end
      OP_RD: begin
        w_next_col = r_addr_col + 3'd1;
        if (r_addr_col == 3'd7) begin
          w_next_bank = r_addr_bank + 4'd1;
        end else begin
          w_next_bank = r_addr_bank;
        end
      end
      default: begin
        w_next_bank = r_addr_bank;
        w_next_col  = r_addr_col;
      end
    endcase
  end

  // Two-entry command FIFO: push on accepted handshake, pop when the sequencer loads
  always_ff @(posedge clk_inv or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_cmd_in;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer FSM: loads commands, issues beats, inserts gap cycles, drives registered outputs
  always_ff @(posedge clk_inv or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_NOP;
      r_beat_cnt  <= 4'd0;
      r_cyc_cnt   <= 4'd0;
      r_gap_cnt   <= 2'd0;
      r_data      <= 16'd0;
      r_op_code   <= OP_NOP;
      r_addr_bank <= 4'd0;
      r_addr_col  <= 3'd0;
      r_data_bank <= 16'd0;
      r_data_in   <= 16'd0;
      r_done      <= 1'b0;
    end else if (w_pop) begin
      // Load the head command; its first beat appears right after this edge.
      // When popping straight out of a finishing command, that command's done fires now.
      r_done     <= w_cmd_end;
      r_state    <= ST_ISSUE;
      r_op       <= w_head.op;
      r_beat_cnt <= w_head.len;
      r_cyc_cnt  <= MAC_LAST;
      r_data     <= w_head.data;
      if (w_head.op != OP_NOP) begin
        r_op_code   <= w_head.op;
        r_addr_bank <= w_head.bank;
        r_addr_col  <= w_head.col;
        r_data_bank <= w_head.data;
        if (w_head.op == OP_MAC) begin
          r_data_in <= w_head.data;
        end else begin
          r_data_in <= r_data_in;
        end
      end else begin
        r_op_code <= OP_NOP;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_op_code <= OP_NOP;
        end
        ST_ISSUE: begin
          if (w_cmd_end) begin
            r_done    <= 1'b1;
            r_op_code <= OP_NOP;
            if (GAP_EN) begin
              r_state   <= ST_GAP;
              r_gap_cnt <= GAP_LAST;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_beat_end) begin
            r_beat_cnt  <= r_beat_cnt - 4'd1;
            r_cyc_cnt   <= MAC_LAST;
            r_addr_bank <= w_next_bank;
            r_addr_col  <= w_next_col;
            if (r_op == OP_MAC) begin
              r_data_in <= r_data;
            end else begin
              r_data_in <= r_data_in;
            end
          end else begin
            // Inside a multi-cycle MAC beat.
            r_cyc_cnt <= r_cyc_cnt - 4'd1;
`ifdef CIM_SEQ_MAC_GATE_EN
            r_data_in <= 16'd0;
`else
            r_data_in <= r_data;
`endif
          end
        end
        ST_GAP: begin
          r_op_code <= OP_NOP;
          if (w_gap_end) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 2'd1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_op_code <= OP_NOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cim_cmd_seq.sv
// Testbench for cim_cmd_seq: directed scenarios followed by random traffic,
// every cycle compared against a frame-list reference model of the sequencer.
module tb_cim_cmd_seq;

  localparam int MAC_CYC = 2;
  localparam int GAP_CYC = 2;
`ifdef CIM_SEQ_MAC_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic        clk_inv = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_bank;
  logic [2:0]  cmd_col;
  logic [3:0]  cmd_len;
  logic [15:0] cmd_data;
  logic [1:0]  op_code;
  logic [3:0]  addr_bank;
  logic [2:0]  addr_col;
  logic [15:0] data_bank;
  logic [15:0] data_in;
  logic        busy;
  logic        done;

  always #5 clk_inv = ~clk_inv;

  cim_cmd_seq #(.MAC_CYC(MAC_CYC), .GAP_CYC(GAP_CYC)) dut (
    .clk_inv(clk_inv), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_bank(cmd_bank), .cmd_col(cmd_col), .cmd_len(cmd_len),
    .cmd_data(cmd_data), .op_code(op_code), .addr_bank(addr_bank), .addr_col(addr_col),
    .data_bank(data_bank), .data_in(data_in), .busy(busy), .done(done)
  );

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  bank;
    logic [2:0]  col;
    logic [3:0]  len;
    logic [15:0] data;
  } cmd_s;

  // One frame = what the outputs show for one cycle.
  typedef struct {
    logic [1:0]  op;
    logic [3:0]  bank;
    logic [2:0]  col;
    logic [15:0] dbank;
    logic [15:0] din;
    bit          fin;
  } frame_s;

  cmd_s   m_fifo[$];
  frame_s m_frames[$];
  frame_s m_cur;
  bit     m_cur_idle;
  bit     m_done;
  bit     m_accepted;
  int     vectors = 0;
  int     miscompares = 0;
  int     done_seen = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_fifo.delete();
    m_frames.delete();
    m_cur      = '{op: 2'b11, bank: 4'd0, col: 3'd0, dbank: 16'd0, din: 16'd0, fin: 1'b0};
    m_cur_idle = 1'b1;
    m_done     = 1'b0;
    m_accepted = 1'b0;
  endfunction

  // Turn one command into its complete list of output frames, gap included.
  function automatic void expand(input cmd_s c);
    frame_s f;
    int     k;
    int     lin;
    f = m_cur;
    if (c.op == 2'b11) begin
      f.op  = 2'b11;
      f.fin = 1'b1;
      m_frames.push_back(f);
    end else begin
      k = (c.op == 2'b00) ? MAC_CYC : 1;
      for (int b = 0; b <= int'(c.len); b++) begin
        for (int j = 0; j < k; j++) begin
          f       = m_cur;
          f.op    = c.op;
          f.dbank = c.data;
          if (c.op == 2'b01) begin
            f.bank = 4'((int'(c.bank) + b) % 16);
            f.col  = c.col;
          end else if (c.op == 2'b10) begin
            lin    = int'(c.bank) * 8 + int'(c.col) + b;
            f.bank = 4'((lin / 8) % 16);
            f.col  = 3'(lin % 8);
          end else begin
            f.bank = c.bank;
            f.col  = c.col;
            f.din  = (GATE && j != 0) ? 16'd0 : c.data;
          end
          f.fin = (b == int'(c.len)) && (j == k - 1);
          m_frames.push_back(f);
        end
      end
    end
    f     = m_frames[$];
    f.op  = 2'b11;
    f.fin = 1'b0;
    for (int g = 0; g < GAP_CYC; g++) m_frames.push_back(f);
  endfunction

  // Advance the model by one active clock edge.
  function automatic void model_edge(input bit valid, input cmd_s c);
    bit acc;
    acc    = valid && (m_fifo.size() < 2);
    m_done = m_cur.fin;
    if (m_frames.size() > 0) begin
      m_cur      = m_frames.pop_front();
      m_cur_idle = 1'b0;
    end else if (m_fifo.size() > 0) begin
      expand(m_fifo.pop_front());
      m_cur      = m_frames.pop_front();
      m_cur_idle = 1'b0;
    end else begin
      m_cur.op   = 2'b11;
      m_cur.fin  = 1'b0;
      m_cur_idle = 1'b1;
    end
    if (acc) m_fifo.push_back(c);
    m_accepted = acc;
  endfunction

  task automatic check_all();
    chk("op_code", 16'(op_code), 16'(m_cur.op));
    chk("addr_bank", 16'(addr_bank), 16'(m_cur.bank));
    chk("addr_col", 16'(addr_col), 16'(m_cur.col));
    chk("data_bank", data_bank, m_cur.dbank);
    chk("data_in", data_in, m_cur.din);
    chk("done", 16'(done), 16'(m_done));
    chk("busy", 16'(busy), 16'(!m_cur_idle || m_fifo.size() != 0));
    chk("cmd_ready", 16'(cmd_ready), 16'(m_fifo.size() < 2));
    if (done === 1'b1) done_seen++;
  endtask

  task automatic step(input bit v, input logic [1:0] op, input logic [3:0] bank,
                      input logic [2:0] col, input logic [3:0] len, input logic [15:0] data);
    cmd_s c;
    c = '{op: op, bank: bank, col: col, len: len, data: data};
    cmd_valid = v; cmd_op = op; cmd_bank = bank; cmd_col = col; cmd_len = len; cmd_data = data;
    @(posedge clk_inv);
    if (rst_n) model_edge(v, c);
    @(negedge clk_inv);
    check_all();
  endtask

  task automatic step_idle();
    step(1'b0, 2'b00, 4'd0, 3'd0, 4'd0, 16'd0);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((!m_cur_idle || m_fifo.size() != 0) && i < 500) begin
      step_idle();
      i++;
    end
    chk("drain_timeout", 16'(i < 500), 16'd1);
    chk("drain_busy", 16'(busy), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_bank = 4'd0; cmd_col = 3'd0;
    cmd_len = 4'd0; cmd_data = 16'd0;
    model_reset();
    @(negedge clk_inv);
    check_all();
    step_idle();
    rst_n = 1'b1;
    step_idle();
    chk("rst_op", 16'(op_code), 16'h0003);
    chk("rst_ready", 16'(cmd_ready), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);

    // Write with bank wrap 14,15,0,1
    step(1'b1, 2'b01, 4'd14, 3'd5, 4'd3, 16'h00A5);
    step_idle(); chk("wr_b0", 16'(addr_bank), 16'd14); chk("wr_op", 16'(op_code), 16'd1);
    chk("wr_data", data_bank, 16'h00A5);
    step_idle(); chk("wr_b1", 16'(addr_bank), 16'd15);
    step_idle(); chk("wr_b2", 16'(addr_bank), 16'd0);
    step_idle(); chk("wr_b3", 16'(addr_bank), 16'd1); chk("wr_col", 16'(addr_col), 16'd5);
    step_idle(); chk("wr_done", 16'(done), 16'd1); chk("wr_gap_op", 16'(op_code), 16'd3);
    step_idle(); chk("wr_done_pulse", 16'(done), 16'd0);
    drain();

    // Read with column wrap into next bank
    step(1'b1, 2'b10, 4'd2, 3'd6, 4'd2, 16'h1234);
    step_idle(); chk("rd_b0", 16'(addr_bank), 16'd2); chk("rd_c0", 16'(addr_col), 16'd6);
    chk("rd_op", 16'(op_code), 16'd2);
    step_idle(); chk("rd_b1", 16'(addr_bank), 16'd2); chk("rd_c1", 16'(addr_col), 16'd7);
    step_idle(); chk("rd_b2", 16'(addr_bank), 16'd3); chk("rd_c2", 16'(addr_col), 16'd0);
    drain();

    // MAC, two beats of two cycles each
    step(1'b1, 2'b00, 4'd9, 3'd3, 4'd1, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      step_idle();
      chk("mac_op", 16'(op_code), 16'd0);
      chk("mac_din", data_in, (GATE && (i % 2 == 1)) ? 16'h0000 : 16'hBEEF);
    end
    step_idle(); chk("mac_done", 16'(done), 16'd1);
    drain();

    // Back-pressure: one long command in flight, then three pushes
    done_seen = 0;
    step(1'b1, 2'b01, 4'd0, 3'd0, 4'd7, 16'h1111);
    step_idle();
    step(1'b1, 2'b10, 4'd1, 3'd1, 4'd1, 16'h2222);
    step(1'b1, 2'b00, 4'd2, 3'd2, 4'd0, 16'h3333);
    chk("bp_ready", 16'(cmd_ready), 16'd0);
    begin
      int n;
      n = 0;
      do begin
        step(1'b1, 2'b01, 4'd3, 3'd3, 4'd0, 16'h4444);
        n++;
      end while (!m_accepted && n < 100);
      chk("bp_accept", 16'(m_accepted), 16'd1);
    end
    drain();
    chk("bp_dones", 16'(done_seen), 16'd4);

    // NOP followed by a single-beat write, with two gap cycles
    step(1'b1, 2'b11, 4'd0, 3'd0, 4'd0, 16'h0000);
    step(1'b1, 2'b01, 4'd4, 3'd1, 4'd0, 16'h5A5A);
    chk("nop_op", 16'(op_code), 16'd3);
    step_idle(); chk("nop_done", 16'(done), 16'd1);
    step_idle(); chk("nop_gap", 16'(done), 16'd0);
    step_idle(); chk("ng_wr_op", 16'(op_code), 16'd1); chk("ng_wr_bank", 16'(addr_bank), 16'd4);
    step_idle(); chk("ng_done", 16'(done), 16'd1); chk("ng_gap1", 16'(op_code), 16'd3);
    step_idle(); chk("ng_gap2", 16'(op_code), 16'd3); chk("ng_gap2_busy", 16'(busy), 16'd1);
    step_idle(); chk("ng_idle_busy", 16'(busy), 16'd0);
    drain();

    // Reset in the middle of a write burst
    step(1'b1, 2'b01, 4'd6, 3'd2, 4'd7, 16'hC3C3);
    step_idle();
    step_idle();
    chk("mr_beat2", 16'(addr_bank), 16'd7);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mr_op", 16'(op_code), 16'd3);
    chk("mr_bank", 16'(addr_bank), 16'd0);
    chk("mr_dbank", data_bank, 16'd0);
    chk("mr_done", 16'(done), 16'd0);
    chk("mr_busy", 16'(busy), 16'd0);
    step_idle();
    step_idle();
    rst_n = 1'b1;
    step_idle(); chk("mr_after_busy", 16'(busy), 16'd0);
    step_idle(); chk("mr_after_done", 16'(done), 16'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 5)), 16'($urandom));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
